// File: rtl/qbert_test2_pkg.sv
// rtl/qbert_test2_pkg.sv - shared state type and default sizing for the qbert_test2 memory copier
package qbert_test2_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 5000;

    localparam logic [DATA_W_DEF/8-1:0] BE_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/qbert_test2_addr_wrap.sv
// rtl/qbert_test2_addr_wrap.sv - word pointer increment that wraps to zero after DEPTH-1
module qbert_test2_addr_wrap
    import qbert_test2_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] ptr_next
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    assign ptr_next = (ptr == LAST) ? '0 : ptr + ADDR_W'(1);

endmodule

// File: rtl/qbert_test2_mem_copier.sv
// rtl/qbert_test2_mem_copier.sv - Avalon-MM word copier/filler; fill mode built only with QBERT_MEMCPY_FILL_EN
module qbert_test2_mem_copier
    import qbert_test2_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     length,
    input  logic                fill,
    input  logic [DATA_W-1:0]   fill_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    input  logic                avm_waitrequest
);

    state_t state, state_next;

    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [ADDR_W-1:0] src_ptr_inc, dst_ptr_inc;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] wr_word;
    logic              fill_sel;
    logic              fill_mode;
    logic              launch;
    logic              wr_accept;

    assign launch    = (state == ST_IDLE) && start && (length != '0);
    assign wr_accept = (state == ST_WR) && !avm_waitrequest;

    assign avm_byteenable = {(DATA_W/8){BE_ALL_ONES[0]}};

`ifdef QBERT_MEMCPY_FILL_EN
    logic [DATA_W-1:0] fill_reg;

    assign fill_sel = fill;
    assign wr_word  = fill_mode ? fill_reg : data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_mode <= 1'b0;
            fill_reg  <= '0;
        end else if (launch) begin
            fill_mode <= fill;
            fill_reg  <= fill_data;
        end
    end
`else
    logic unused_fill;

    assign unused_fill = ^{fill, fill_data};
    assign fill_sel    = 1'b0;
    assign fill_mode   = 1'b0;
    assign wr_word     = data_reg;
`endif

    qbert_test2_addr_wrap #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_src_wrap (
        .ptr      (src_ptr),
        .ptr_next (src_ptr_inc)
    );

    qbert_test2_addr_wrap #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dst_wrap (
        .ptr      (dst_ptr),
        .ptr_next (dst_ptr_inc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus strobes and address come straight from the state so reset clears them at once.
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = fill_sel ? ST_WR : ST_RD;
                    end
                end
            end
            ST_RD: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = src_ptr;
                if (!avm_waitrequest) begin
                    state_next = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    state_next = ST_WR;
                end
            end
            ST_WR: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = dst_ptr;
                avm_writedata = wr_word;
                if (!avm_waitrequest) begin
                    if (count == (ADDR_W+1)'(1)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = fill_mode ? ST_WR : ST_RD;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
        end else begin
            if (launch) begin
                src_ptr <= src_addr;
                dst_ptr <= dst_addr;
                count   <= length;
            end else if (wr_accept) begin
                src_ptr <= src_ptr_inc;
                dst_ptr <= dst_ptr_inc;
                count   <= count - (ADDR_W+1)'(1);
            end
            if ((state == ST_RWAIT) && avm_readdatavalid) begin
                data_reg <= avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_qbert_test2_mem_copier.sv
// tb/tb_qbert_test2_mem_copier.sv - randomized Avalon slave plus sequential copy model for the mem copier
module tb_qbert_test2_mem_copier;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 5000;
`ifdef QBERT_MEMCPY_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              fill = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
    logic              busy, done, avm_read, avm_write;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic              avm_waitrequest = 1'b0;

    qbert_test2_mem_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .length            (length),
        .fill              (fill),
        .fill_data         (fill_data),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    int exp_rd[$];
    int exp_wa[$];
    logic [DATA_W-1:0] exp_wd[$];
    int obs_rd[$];
    int obs_wa[$];

    int rd_cd = 0;
    logic [DATA_W-1:0] rd_data = '0;
    int lat_mode = 1;
    int stall_mode = 0;
    int stall_left = 0;
    bit in_acc = 1'b0;
    bit prev_stalled = 1'b0;
    logic [ADDR_W+DATA_W+1:0] prev_bus = '0;
    int done_count = 0;
    int strobe_count = 0;
    int rd_acc_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave and protocol monitor: runs at every falling edge, deciding what the next rising edge sees.
    task automatic bus_step();
        logic wr;
        logic [ADDR_W+DATA_W+1:0] cur;
        avm_readdatavalid = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = rd_data;
            end
        end
        if (!reset_n) begin
            avm_waitrequest = 1'b0;
            in_acc = 1'b0;
            prev_stalled = 1'b0;
        end else begin
            cur = {avm_read, avm_write, avm_address, avm_writedata};
            if (prev_stalled) chk("stall_hold", cur, prev_bus);
            chk("rd_wr_exclusive", avm_read && avm_write, 1'b0);
            if (done) begin
                done_count++;
                chk("done_not_busy", busy, 1'b0);
            end
            wr = 1'b0;
            if (avm_read || avm_write) begin
                strobe_count++;
                if (!in_acc) begin
                    in_acc = 1'b1;
                    stall_left = (stall_mode == 2) ? 3 : (stall_mode == 1) ? int'($urandom_range(0, 2)) : 0;
                end
                wr = (stall_left > 0);
                if (wr) stall_left--;
                else in_acc = 1'b0;
            end else begin
                in_acc = 1'b0;
            end
            avm_waitrequest = wr;
            prev_stalled = (avm_read || avm_write) && wr;
            prev_bus = cur;
            if (avm_read && !wr) begin
                rd_acc_count++;
                obs_rd.push_back(int'(avm_address));
                chk("rd_expected", exp_rd.size() > 0, 1'b1);
                if (exp_rd.size() > 0) chk("rd_addr", avm_address, exp_rd.pop_front());
                rd_data = (avm_address < DEPTH) ? mem[avm_address] : 'x;
                rd_cd = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            end
            if (avm_write && !wr) begin
                obs_wa.push_back(int'(avm_address));
                chk("wr_be", avm_byteenable, 4'hF);
                chk("wr_expected", exp_wa.size() > 0, 1'b1);
                if (exp_wa.size() > 0) begin
                    chk("wr_addr", avm_address, exp_wa.pop_front());
                    chk("wr_data", avm_writedata, exp_wd.pop_front());
                end
                if (avm_address < DEPTH) mem[avm_address] = avm_writedata;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            bus_step();
        end
    end

    // Sequential word-by-word model: word i of the destination gets the source word as it stands then.
    task automatic run_xfer(input int src, input int dst, input int len, input bit f,
                            input logic [DATA_W-1:0] fd, input int sm, input int lm,
                            input int ecyc, input bit poke);
        bit eff_fill;
        int n, dc0, mism, s, d;
        logic [DATA_W-1:0] v;
        eff_fill = f && FILL_EN;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < len; i++) begin
            s = (src + i) % DEPTH;
            d = (dst + i) % DEPTH;
            if (eff_fill) begin
                v = fd;
            end else begin
                exp_rd.push_back(s);
                v = ref_mem[s];
            end
            ref_mem[d] = v;
            exp_wa.push_back(d);
            exp_wd.push_back(v);
        end
        stall_mode = sm;
        lat_mode = lm;
        @(negedge clk); #1;
        dc0 = done_count;
        src_addr = ADDR_W'(src); dst_addr = ADDR_W'(dst); length = (ADDR_W+1)'(len);
        fill = f; fill_data = fd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done_count == dc0 && n < 40 * len + 40) begin
            @(negedge clk); #1;
            n++;
            if (poke && n == 3) begin
                src_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                dst_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                length = (ADDR_W+1)'($urandom_range(1, 50));
                fill = 1'($urandom); fill_data = $urandom; start = 1'b1;
            end
            if (n == 4) start = 1'b0;
        end
        start = 1'b0;
        chk("done_seen", done_count - dc0, 1);
        if (ecyc >= 0) chk("cycles_to_done", n, ecyc);
        repeat (3) @(negedge clk);
        #1;
        chk("done_single", done_count - dc0, 1);
        chk("busy_after", busy, 1'b0);
        chk("reads_left", exp_rd.size(), 0);
        chk("writes_left", exp_wa.size(), 0);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", mism, 0);
    endtask

    task automatic reset_midop();
        int n, ra0, dc0;
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        exp_rd.push_back(500);
        stall_mode = 0;
        lat_mode = 3;
        ra0 = rd_acc_count;
        @(negedge clk); #1;
        src_addr = ADDR_W'(500); dst_addr = ADDR_W'(600); length = (ADDR_W+1)'(3);
        fill = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (rd_acc_count == ra0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_read_seen", rd_acc_count - ra0, 1);
        dc0 = done_count;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("rst_no_done", done_count - dc0, 0);
        chk("rst_idle_busy", busy, 1'b0);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    endtask

    initial begin
        int sc0, ra, rl;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #1 reset_n = 1'b0;
        #3;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_read", avm_read, 1'b0);
        chk("reset_write", avm_write, 1'b0);
        chk("reset_addr", avm_address, 0);
        chk("reset_wdata", avm_writedata, 0);
        chk("reset_be", avm_byteenable, 4'hF);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        mem[10] = 32'hA0A0_0001; mem[11] = 32'hB0B0_0002; mem[12] = 32'hC0C0_0003; mem[13] = 32'hD0D0_0004;
        for (int i = 10; i < 14; i++) ref_mem[i] = mem[i];
        run_xfer(10, 100, 4, 1'b0, '0, 0, 1, 13, 1'b0);
        chk("copy_w100", mem[100], 32'hA0A0_0001);
        chk("copy_w101", mem[101], 32'hB0B0_0002);
        chk("copy_w102", mem[102], 32'hC0C0_0003);
        chk("copy_w103", mem[103], 32'hD0D0_0004);

        sc0 = strobe_count;
        run_xfer(50, 60, 0, 1'b0, '0, 0, 1, 1, 1'b0);
        chk("zero_len_strobes", strobe_count - sc0, 0);

        run_xfer(200, 400, 3, 1'b0, '0, 2, 1, -1, 1'b0);

        obs_rd.delete(); obs_wa.delete();
        run_xfer(4998, 0, 4, 1'b0, '0, 0, 1, 13, 1'b0);
        chk("wrap_rd_count", obs_rd.size(), 4);
        chk("wrap_rd0", obs_rd[0], 4998);
        chk("wrap_rd1", obs_rd[1], 4999);
        chk("wrap_rd2", obs_rd[2], 0);
        chk("wrap_rd3", obs_rd[3], 1);
        chk("wrap_wr0", obs_wa[0], 0);
        chk("wrap_wr3", obs_wa[3], 3);

        mem[300] = 32'h1111_2222; mem[301] = 32'h3333_4444; mem[302] = 32'h5555_6666;
        for (int i = 300; i < 303; i++) ref_mem[i] = mem[i];
        obs_rd.delete();
        run_xfer(300, 20, 3, 1'b1, 32'hDEADBEEF, 0, 1, FILL_EN ? 4 : 10, 1'b0);
        chk("fill_reads", obs_rd.size(), FILL_EN ? 0 : 3);
        chk("fill_w20", mem[20], FILL_EN ? 32'hDEADBEEF : 32'h1111_2222);
        chk("fill_w21", mem[21], FILL_EN ? 32'hDEADBEEF : 32'h3333_4444);
        chk("fill_w22", mem[22], FILL_EN ? 32'hDEADBEEF : 32'h5555_6666);

        reset_midop();
        run_xfer(500, 600, 3, 1'b0, '0, 0, 1, 10, 1'b0);

        for (int t = 0; t < 10; t++) begin
            ra = (t < 3) ? int'($urandom_range(DEPTH - 8, DEPTH - 1)) : int'($urandom_range(0, DEPTH - 1));
            rl = $urandom_range(0, 16);
            run_xfer(ra, int'($urandom_range(0, DEPTH - 1)), rl, 1'($urandom), $urandom, 1, 0, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qbert_test2_mem_copier.md
QBERT_TEST2_MEM_COPIER -- requirements
Module: qbert_test2_mem_copier

Interface
REQ-001 Parameter ADDR_W, default 13: Avalon word-address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter DEPTH, default 5000: words in target memory; addresses wrap at DEPTH.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a transfer.
REQ-007 src_addr / dst_addr  in  ADDR_W  first source / destination word address, sampled at start.
REQ-008 length  in  ADDR_W+1  word count, sampled at start.
REQ-009 fill / fill_data  in  1 / DATA_W  fill-mode select and pattern, sampled at start.
REQ-010 busy  out  1  transfer in progress.
REQ-011 done  out  1  one-cycle pulse at completion.
REQ-012 avm_address  out  ADDR_W  Avalon-MM master word address.
REQ-013 avm_read / avm_write  out  1  Avalon read / write strobes.
REQ-014 avm_byteenable  out  DATA_W/8  constant all-ones.
REQ-015 avm_writedata  out  DATA_W  write data.
REQ-016 avm_readdata  in  DATA_W  read data.
REQ-017 avm_readdatavalid / avm_waitrequest  in  1  Avalon read-valid / stall.

Function
REQ-018 FSM states IDLE, RD, RWAIT, WR, DONE; one outstanding read maximum.
REQ-019 IDLE: start with length != 0 latches src/dst/length/fill/fill_data -> RD (copy) or WR (fill); busy rises next cycle.
REQ-020 IDLE: start with length == 0 -> DONE directly, no bus access.
REQ-021 start while busy is ignored; latched parameters are not altered.
REQ-022 RD: avm_read=1, avm_address=src pointer; held stable while avm_waitrequest=1; on accept -> RWAIT.
REQ-023 RWAIT: avm_read=0; first cycle with avm_readdatavalid=1 captures avm_readdata into data register -> WR.
REQ-024 WR: avm_write=1, avm_address=dst pointer, avm_writedata=data register (fill_data in fill mode); held while avm_waitrequest=1.
REQ-025 On write accept: remaining count decrements; src and dst pointers increment; pointer at DEPTH-1 wraps to 0.
REQ-026 After write accept: remaining count 0 -> DONE; else -> RD (copy) or WR (fill).
REQ-027 DONE: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE; start accepted next cycle.
REQ-028 avm_read and avm_write never asserted in the same cycle.
REQ-029 Minimum copy throughput with zero waitrequest and readdatavalid one cycle after accept: one word per 3 cycles; fill: one word per cycle.
REQ-030 Counter is ADDR_W+1 bits; length up to 2^ADDR_W accepted; length > DEPTH wraps and overwrites, no error flagged.

Reset
REQ-031 reset_n low asynchronously forces IDLE; busy, done, avm_read, avm_write = 0; avm_address, avm_writedata, pointers, count, data register = 0.
REQ-032 Reset mid-transfer abandons the transfer with no done pulse; a pending readdatavalid after release is ignored in IDLE.
REQ-033 Release of reset_n is synchronized externally; first start is honoured on the first clk edge after release.

Configuration
REQ-034 Macro QBERT_MEMCPY_FILL_EN defined: fill input honoured per REQ-019/REQ-024/REQ-026.
REQ-035 Macro QBERT_MEMCPY_FILL_EN undefined: fill and fill_data ports remain but are ignored; every transfer is a copy; fill data register logic removed.

Structure
REQ-036 Shared package qbert_test2_pkg holds state enum type, default ADDR_W/DATA_W/DEPTH constants and the all-ones byteenable constant.
REQ-037 One sub-module, qbert_test2_addr_wrap, implements the increment-and-wrap-at-DEPTH pointer (instantiated for src and dst).

Verification
REQ-038 Copy: memory[10..13]=A,B,C,D, start src=10 dst=100 length=4 -> memory[100..103]=A,B,C,D, single done pulse, busy low after.
REQ-039 Zero length: start length=0 -> done one cycle after start cycle +1, no avm_read/avm_write ever asserted.
REQ-040 Waitrequest: slave stalls 3 cycles on each access -> avm_address/avm_writedata stable through stall, data correct.
REQ-041 Wrap: src=4998 dst=0 length=4 -> reads 4998,4999,0,1 in order; dst writes 0..3.
REQ-042 Fill (macro defined): fill=1 fill_data=32'hDEADBEEF dst=20 length=3 -> words 20..22 = DEADBEEF, no reads; macro undefined -> copy performed.
REQ-043 Reset mid-op: reset_n low in RWAIT -> outputs 0 immediately, no done; new start after release completes normally.
